node_route_counter: RTL and testbench
=====================================

# node_route_counter

Synchronous, parametrised node counter for the line-following path tracker. It samples the raw node-detect signal on the system clock, synchronises and debounces it, and counts confirmed nodes across a configurable number of laps. Later laps restart from a re-entry value, and the block parks at a terminal code when the route is complete. It sits between the sensor front end and the path-planning FSM, which reads `node_cnt`, `lap` and `run_done`.

## Interface
Parameters:
- `CNT_W`, 3: width of `node_cnt`.
- `LAP_LAST`, 6: count value at which a lap ends.
- `REENTRY`, 2: value loaded into `node_cnt` when a lap ends and more laps remain.
- `NUM_LAPS`, 2: total laps, ≥1.
- `DONE_VAL`, 7: terminal count value.
- `DEB_CYC`, 4: number of consecutive stable samples needed to accept a level, ≥1.
- `LAP_W`, 2: width of `lap`; must hold `NUM_LAPS-1`.

Ports:
- `clk` input 1: system clock. Every flop is on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `en` input 1: counting enable. While low, node events are discarded; the debouncer keeps running.
- `clear` input 1: synchronous restart of count, lap and state.
- `node_det` input 1: raw node sensor, asynchronous to `clk`.
- `node_cnt` output CNT_W: current node count.
- `lap` output LAP_W: current lap index, 0-based.
- `node_pulse` output 1: one-cycle strobe per accepted node event.
- `lap_done` output 1: one-cycle strobe when a lap ends with laps remaining.
- `run_done` output 1: level, high in the DONE state.

## Operation
- Front end: 2-flop synchroniser, then a debouncer. The debounced level changes only after `DEB_CYC` consecutive samples that differ from it. A rising edge of the debounced level produces the internal event `ev` for one cycle.
- The counting FSM is held in a shared package enum and has three states.
- IDLE:
  - Entered on reset or `clear`.
  - Moves to RUN on the first cycle with `en`=1.
  - An `ev` arriving on that same cycle is counted.
- RUN, on `ev` && `en`:
  - If `node_cnt` ≠ `LAP_LAST`: `node_cnt`+1.
  - If `node_cnt` = `LAP_LAST` and `lap` < `NUM_LAPS-1`: `node_cnt`←`REENTRY`, `lap`+1, `lap_done` pulses.
  - If `node_cnt` = `LAP_LAST` and `lap` = `NUM_LAPS-1`: `node_cnt`←`DONE_VAL`, move to DONE.
- RUN with `en`=0: the state holds and `ev` is dropped. There is no deferred counting.
- DONE:
  - `run_done`=1.
  - All `ev` are ignored and nothing wraps.
  - Only `clear` or reset leaves this state.
- Every counted event pulses `node_pulse`, including the lap-end and done transitions.
- Priority: `rst_n`=0 > `clear` > `ev`. A `clear` coincident with `ev` yields count 0 and no pulse.
- `clear` does not reset the synchroniser or the debouncer. Reset does, to level 0.
- Arithmetic:
  - Unsigned, width `CNT_W`.
  - Parameter legality: `REENTRY` < `LAP_LAST` < 2^CNT_W and `DONE_VAL` < 2^CNT_W.
  - Elaboration fails through a generate-time check otherwise.
- With `NUM_LAPS`=1, the first `LAP_LAST` event goes straight to DONE.

## Timing
- Reset values:
  - `node_cnt`=0, `lap`=0, `node_pulse`=0, `lap_done`=0, `run_done`=0.
  - State IDLE; synchroniser and debouncer at 0.
- Latency from `node_det` rising, then held stable, to `ev` is 2 + `DEB_CYC` cycles.
- `node_cnt`, `lap`, `node_pulse`, `lap_done` and `run_done` are all registered. They update on the edge after `ev` and are mutually coherent in that cycle.
- Minimum event spacing is 2×`DEB_CYC` cycles: high time plus low time. Shorter glitches are filtered.
- `rst_n` sampled low mid-debounce discards the partial filter count.

## Structure
- Package `node_pkg`:
  - State enum {IDLE, RUN, DONE}.
  - Default parameter constants.
  - A `clog2` helper used to size the debounce counter.
- Sub-module `node_debounce`: synchroniser, `DEB_CYC` filter and rising-edge detect. Its single output is `ev`.
- Top level: FSM plus the count and lap registers.

## Test plan
All scenarios use default parameters.
- Reset: hold `rst_n`=0 for 3 cycles → all outputs 0; after release with `en`=1 and no `node_det` activity, outputs stay 0.
- First lap: 7 clean pulses, each high 8 and low 8 cycles → `node_cnt` steps 1..6, then the 7th pulse gives `node_cnt`=2, `lap`=1 and a single `lap_done` pulse.
- Completion: continue with 5 more pulses → 3, 4, 5, 6, then 7 with `run_done`=1; 3 further pulses leave `node_cnt`=7 with no `node_pulse`.
- Debounce: high for 3 cycles → no event. High for 4 cycles → exactly one event, with `node_pulse` 2+4+1 cycles after the rise.
- Enable gating: `en`=0 during 2 pulses → count unchanged. Re-enable and send 1 pulse → count +1.
- Clear: `clear` coincident with an `ev` at count 5 → `node_cnt`=0, `lap`=0, state IDLE, no `node_pulse`. `clear` issued from DONE → `run_done` deasserts on the next cycle.

Source files
------------

// File: rtl/node_pkg.sv
// Shared types and defaults for the line-follower node counter.
package node_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_CNT_W    = 3;
  localparam int DEF_LAP_LAST = 6;
  localparam int DEF_REENTRY  = 2;
  localparam int DEF_NUM_LAPS = 2;
  localparam int DEF_DONE_VAL = 7;
  localparam int DEF_DEB_CYC  = 4;
  localparam int DEF_LAP_W    = 2;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/node_debounce.sv
// Node-detect front end: 2-flop synchroniser, stable-sample filter and
// rising-edge strobe of the filtered level.
module node_debounce
  import node_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic node_det,
  output logic ev
);

  // Counter only needs to reach DEB_CYC-1; the +1 keeps it at least 1 bit wide.
  localparam int              RUN_W    = clog2(DEB_CYC + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEB_CYC - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             ev_q, ev_d;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    sync_d  = {sync_q[0], node_det};
    level_d = level_q;
    run_d   = '0;
    if (sync_q[1] != level_q) begin
      if (run_q == RUN_LAST) level_d = ~level_q;
      else                   run_d   = run_q + 1'b1;
    end
    ev_d = level_d & ~level_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // sample their _d values from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      run_q   <= '0;
      ev_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      run_q   <= run_d;
      ev_q    <= ev_d;
    end
  end

  assign ev = ev_q;

endmodule

// File: rtl/node_route_counter.sv
// Route node counter: counts debounced node events over NUM_LAPS laps,
// reloading REENTRY between laps and parking at DONE_VAL when finished.
module node_route_counter
  import node_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LAP_LAST = DEF_LAP_LAST,
  parameter int REENTRY  = DEF_REENTRY,
  parameter int NUM_LAPS = DEF_NUM_LAPS,
  parameter int DONE_VAL = DEF_DONE_VAL,
  parameter int DEB_CYC  = DEF_DEB_CYC,
  parameter int LAP_W    = DEF_LAP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             node_det,
  output logic [CNT_W-1:0] node_cnt,
  output logic [LAP_W-1:0] lap,
  output logic             node_pulse,
  output logic             lap_done,
  output logic             run_done
);

  if (!(REENTRY < LAP_LAST && LAP_LAST < (1 << CNT_W) && DONE_VAL < (1 << CNT_W) &&
        NUM_LAPS >= 1 && DEB_CYC >= 1 && (NUM_LAPS - 1) < (1 << LAP_W))) begin : g_bad_params
    $error("node_route_counter: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(LAP_LAST);
  localparam logic [CNT_W-1:0] REENTRY_C = CNT_W'(REENTRY);
  localparam logic [CNT_W-1:0] DONE_C    = CNT_W'(DONE_VAL);
  localparam logic [LAP_W-1:0] LAP_END_C = LAP_W'(NUM_LAPS - 1);

  logic ev;

  node_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .node_det (node_det),
    .ev       (ev)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic             pulse_q, pulse_d;
  logic             lap_done_q, lap_done_d;
  logic             run_done_q, run_done_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lap_d      = lap_q;
    pulse_d    = 1'b0;
    lap_done_d = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      lap_d   = '0;
    end else begin
      case (state_q)
        // IDLE and RUN count identically; IDLE just arms on the first enable.
        ST_IDLE, ST_RUN: begin
          if (en) begin
            state_d = ST_RUN;
            if (ev) begin
              pulse_d = 1'b1;
              if (cnt_q != LAST_C) begin
                cnt_d = cnt_q + 1'b1;
              end else if (lap_q < LAP_END_C) begin
                cnt_d      = REENTRY_C;
                lap_d      = lap_q + 1'b1;
                lap_done_d = 1'b1;
              end else begin
                cnt_d   = DONE_C;
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end

    run_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lap_q      <= '0;
      pulse_q    <= 1'b0;
      lap_done_q <= 1'b0;
      run_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lap_q      <= lap_d;
      pulse_q    <= pulse_d;
      lap_done_q <= lap_done_d;
      run_done_q <= run_done_d;
    end
  end

  assign node_cnt   = cnt_q;
  assign lap        = lap_q;
  assign node_pulse = pulse_q;
  assign lap_done   = lap_done_q;
  assign run_done   = run_done_q;

endmodule

// File: tb/tb_node_route_counter.sv
// Self-checking bench for node_route_counter: directed vector table, hand
// sequences for clear/reset corner cases, and randomized pulses vs a route model.
module tb_node_route_counter;

  localparam int CNT_W    = 3;
  localparam int LAP_LAST = 6;
  localparam int REENTRY  = 2;
  localparam int NUM_LAPS = 2;
  localparam int DONE_VAL = 7;
  localparam int DEB_CYC  = 4;
  localparam int LAP_W    = 2;
  localparam int LATENCY  = 2 + DEB_CYC + 1;

  logic             clk = 1'b0;
  logic             rst_n, en, clear, node_det;
  logic [CNT_W-1:0] node_cnt;
  logic [LAP_W-1:0] lap;
  logic             node_pulse, lap_done, run_done;

  always #5 clk = ~clk;

  node_route_counter #(
    .CNT_W (CNT_W), .LAP_LAST (LAP_LAST), .REENTRY (REENTRY), .NUM_LAPS (NUM_LAPS),
    .DONE_VAL (DONE_VAL), .DEB_CYC (DEB_CYC), .LAP_W (LAP_W)
  ) dut (
    .clk (clk), .rst_n (rst_n), .en (en), .clear (clear), .node_det (node_det),
    .node_cnt (node_cnt), .lap (lap), .node_pulse (node_pulse),
    .lap_done (lap_done), .run_done (run_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pulse on node_det: high for hi cycles, low for lo cycles, en held at e.
  // Reports how many node_pulse/lap_done strobes were seen and when the first pulse came.
  task automatic run_pulse(input int hi, input int lo, input logic e,
                           output int np, output int nl, output int first);
    np = 0; nl = 0; first = -1;
    en = e;
    node_det = 1'b1;
    for (int k = 1; k <= hi + lo; k++) begin
      tick();
      if (node_pulse) begin
        np++;
        if (first < 0) first = k;
      end
      if (lap_done) nl++;
      if (k == hi) node_det = 1'b0;
    end
  endtask

  // Route position after n counted events, by closed-form arithmetic.
  function automatic void route_model(input int n, output int c, output int lp, output int d);
    int per, m;
    per = LAP_LAST - REENTRY + 1;
    d = 0;
    if (n <= LAP_LAST) begin
      c = n; lp = 0;
    end else begin
      m  = n - LAP_LAST - 1;
      lp = 1 + m / per;
      c  = REENTRY + m % per;
      if (lp > NUM_LAPS - 1) begin
        d = 1; lp = NUM_LAPS - 1; c = DONE_VAL;
      end
    end
  endfunction

  typedef struct {
    int hi; int lo; bit en; bit clr_before;
    int cnt; int lap; int np; int ld; int rd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int np, nl, first, saw;
    int n, c, lp, d, pc, plp, pd, exp_np, exp_ld;

    rst_n = 1'b0; en = 1'b0; clear = 1'b0; node_det = 1'b0;
    repeat (3) tick();
    check("reset_cnt", node_cnt, 0);
    check("reset_lap", lap, 0);
    check("reset_pulse", node_pulse, 0);
    check("reset_lap_done", lap_done, 0);
    check("reset_run_done", run_done, 0);

    rst_n = 1'b1; en = 1'b1;
    saw = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (node_cnt != 0 || lap != 0 || node_pulse || lap_done || run_done) saw++;
    end
    check("idle_quiet", saw, 0);

    for (int i = 1; i <= 6; i++) vecs.push_back('{8, 8, 1'b1, 1'b0, i, 0, 1, 0, 0});
    vecs.push_back('{8, 8, 1'b1, 1'b0, 2, 1, 1, 1, 0});
    for (int i = 3; i <= 6; i++) vecs.push_back('{8, 8, 1'b1, 1'b0, i, 1, 1, 0, 0});
    vecs.push_back('{8, 8, 1'b1, 1'b0, 7, 1, 1, 0, 1});
    repeat (3) vecs.push_back('{8, 8, 1'b1, 1'b0, 7, 1, 0, 0, 1});
    vecs.push_back('{3, 8, 1'b1, 1'b1, 0, 0, 0, 0, 0});
    vecs.push_back('{4, 8, 1'b1, 1'b0, 1, 0, 1, 0, 0});
    repeat (2) vecs.push_back('{8, 8, 1'b0, 1'b0, 1, 0, 0, 0, 0});
    for (int i = 2; i <= 5; i++) vecs.push_back('{8, 8, 1'b1, 1'b0, i, 0, 1, 0, 0});

    foreach (vecs[i]) begin
      if (vecs[i].clr_before) begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check($sformatf("v%0d_clear_run_done", i), run_done, 0);
        check($sformatf("v%0d_clear_cnt", i), node_cnt, 0);
        check($sformatf("v%0d_clear_lap", i), lap, 0);
      end
      run_pulse(vecs[i].hi, vecs[i].lo, vecs[i].en, np, nl, first);
      check($sformatf("v%0d_pulses", i), np, vecs[i].np);
      check($sformatf("v%0d_lap_done", i), nl, vecs[i].ld);
      check($sformatf("v%0d_cnt", i), node_cnt, vecs[i].cnt);
      check($sformatf("v%0d_lap", i), lap, vecs[i].lap);
      check($sformatf("v%0d_run_done", i), run_done, vecs[i].rd);
      if (vecs[i].np == 1) check($sformatf("v%0d_latency", i), first, LATENCY);
    end

    // clear lands on the same cycle as the event at count 5
    en = 1'b1; node_det = 1'b1; saw = 0;
    for (int k = 1; k <= 16; k++) begin
      clear = (k == LATENCY);
      tick();
      if (node_pulse) saw++;
      if (k == LATENCY) begin
        check("clr_ev_cnt", node_cnt, 0);
        check("clr_ev_lap", lap, 0);
        check("clr_ev_pulse", node_pulse, 0);
      end
      if (k == 8) node_det = 1'b0;
    end
    clear = 1'b0;
    check("clr_ev_no_pulse", saw, 0);
    run_pulse(8, 8, 1'b1, np, nl, first);
    check("after_clr_cnt", node_cnt, 1);
    check("after_clr_pulse", np, 1);

    // reset in the middle of a debounce window restarts the filter
    node_det = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    first = -1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (node_pulse && first < 0) first = k;
      if (k == 8) node_det = 1'b0;
    end
    check("mid_reset_latency", first, LATENCY);
    check("mid_reset_cnt", node_cnt, 1);

    // randomized pulses and glitches against the route model
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n = 0;
    for (int it = 0; it < 80; it++) begin
      int hi, lo;
      logic e;
      if ($urandom_range(0, 19) == 0) begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n = 0;
      end
      hi = $urandom_range(1, 10);
      lo = $urandom_range(DEB_CYC, 10);
      e  = ($urandom_range(0, 3) != 0);
      route_model(n, pc, plp, pd);
      exp_np = 0; exp_ld = 0;
      if (hi >= DEB_CYC && e && pd == 0) begin
        n++;
        exp_np = 1;
        route_model(n, c, lp, d);
        if (d == 0 && n > LAP_LAST && ((n - LAP_LAST - 1) % (LAP_LAST - REENTRY + 1)) == 0)
          exp_ld = 1;
      end
      route_model(n, c, lp, d);
      run_pulse(hi, lo, e, np, nl, first);
      check($sformatf("rnd%0d_pulses", it), np, exp_np);
      check($sformatf("rnd%0d_lap_done", it), nl, exp_ld);
      check($sformatf("rnd%0d_cnt", it), node_cnt, c);
      check($sformatf("rnd%0d_lap", it), lap, lp);
      check($sformatf("rnd%0d_run_done", it), run_done, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
